fetch_unit: RTL and testbench

//   Instruction-fetch stage upstream of the instruction memory. Holds the 64-bit PC and drives
//   it as the memory Address. Samples the 32-bit Data after a fixed read latency and hands the

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, samples instruction memory after RD_LATENCY cycles,
// and hands instruction/PC to decode over valid/ready. Optional counters under FETCH_STATS_EN.
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [63:0] Address,
  input  logic [31:0] Data,
  input  logic        Redirect,
  input  logic [63:0] RedirectTarget,
  input  logic        InstReady,
  output logic        InstValid,
  output logic [31:0] Instruction,
  output logic [63:0] InstPC
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] RedirectCount
`endif
);

  localparam logic [0:0] FETCH    = 1'b0;
  localparam logic [0:0] HOLD     = 1'b1;
  localparam logic [3:0] CNT_LAST = 4'(RD_LATENCY - 1);

  logic [63:0] pc_r;
  logic [0:0]  state_r;
  logic [3:0]  cnt_r;
  logic        handshake_s;

  assign Address     = pc_r;
  assign handshake_s = InstValid && InstReady;

  // PC, fetch sequencing and the decode-facing holding register; Redirect wins over everything
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_r        <= RESET_PC;
      state_r     <= FETCH;
      cnt_r       <= 4'd0;
      InstValid   <= 1'b0;
      Instruction <= 32'h0;
      InstPC      <= 64'h0;
    end else if (Redirect) begin
      pc_r      <= RedirectTarget & 64'hFFFF_FFFF_FFFF_FFFC;
      cnt_r     <= 4'd0;
      InstValid <= 1'b0;
      state_r   <= FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          if (cnt_r == CNT_LAST) begin
            Instruction <= Data;
            InstPC      <= pc_r;
            InstValid   <= 1'b1;
            cnt_r       <= 4'd0;
            state_r     <= HOLD;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        HOLD: begin
          if (handshake_s) begin
            pc_r      <= pc_r + 64'd4;
            InstValid <= 1'b0;
            state_r   <= FETCH;
          end else begin
            pc_r <= pc_r;
          end
        end
        default: begin
          cnt_r     <= 4'd0;
          InstValid <= 1'b0;
          state_r   <= FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters; a handshake coinciding with Redirect still counts as a fetch
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      FetchCount    <= 32'd0;
      RedirectCount <= 32'd0;
    end else begin
      if (handshake_s) begin
        FetchCount <= sat_inc(FetchCount);
      end
      if (Redirect) begin
        RedirectCount <= sat_inc(RedirectCount);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit: two instances (RD_LATENCY 1 and 3, the latter
// starting at the top of the address space) checked every cycle against a transaction-level model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Redirect = 1'b0;
  logic [63:0] RedirectTarget = 64'h0;
  logic        InstReady = 1'b0;
  logic [31:0] data  [2];
  logic [63:0] addr  [2];
  logic        valid [2];
  logic [31:0] inst  [2];
  logic [63:0] ipc   [2];
`ifdef FETCH_STATS_EN
  logic [31:0] fcnt  [2];
  logic [31:0] rcnt  [2];
`endif

  int n_checks = 0;
  int n_errors = 0;

  int          lat [2] = '{1, 3};
  logic [63:0] rpc [2] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFC};

  // reference model: fetch is "waiting N more edges" or "holding a word for decode"
  logic [63:0] m_pc    [2];
  logic        m_valid [2];
  int          m_wait  [2];
  logic [31:0] m_inst  [2];
  logic [63:0] m_ipc   [2];
  logic [31:0] m_fc    [2];
  logic [31:0] m_rc    [2];

  always #5 CLK = ~CLK;

  fetch_unit #(.RESET_PC(64'h0), .RD_LATENCY(1)) dut0 (
    .CLK(CLK), .Reset(Reset), .Address(addr[0]), .Data(data[0]),
    .Redirect(Redirect), .RedirectTarget(RedirectTarget), .InstReady(InstReady),
    .InstValid(valid[0]), .Instruction(inst[0]), .InstPC(ipc[0])
`ifdef FETCH_STATS_EN
    , .FetchCount(fcnt[0]), .RedirectCount(rcnt[0])
`endif
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .RD_LATENCY(3)) dut1 (
    .CLK(CLK), .Reset(Reset), .Address(addr[1]), .Data(data[1]),
    .Redirect(Redirect), .RedirectTarget(RedirectTarget), .InstReady(InstReady),
    .InstValid(valid[1]), .Instruction(inst[1]), .InstPC(ipc[1])
`ifdef FETCH_STATS_EN
    , .FetchCount(fcnt[1]), .RedirectCount(rcnt[1])
`endif
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ 32'hF840_03E9;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i]    = rpc[i];
      m_valid[i] = 1'b0;
      m_wait[i]  = lat[i];
      m_inst[i]  = 32'h0;
      m_ipc[i]   = 64'h0;
      m_fc[i]    = 32'h0;
      m_rc[i]    = 32'h0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (Redirect) begin
        if (m_valid[i] && InstReady && m_fc[i] != 32'hFFFF_FFFF) m_fc[i] = m_fc[i] + 32'd1;
        if (m_rc[i] != 32'hFFFF_FFFF) m_rc[i] = m_rc[i] + 32'd1;
        m_pc[i]    = RedirectTarget & 64'hFFFF_FFFF_FFFF_FFFC;
        m_valid[i] = 1'b0;
        m_wait[i]  = lat[i];
      end else if (m_valid[i]) begin
        if (InstReady) begin
          if (m_fc[i] != 32'hFFFF_FFFF) m_fc[i] = m_fc[i] + 32'd1;
          m_pc[i]    = m_pc[i] + 64'd4;
          m_valid[i] = 1'b0;
          m_wait[i]  = lat[i];
        end
      end else begin
        m_wait[i] = m_wait[i] - 1;
        if (m_wait[i] == 0) begin
          m_valid[i] = 1'b1;
          m_inst[i]  = mem_word(m_pc[i]);
          m_ipc[i]   = m_pc[i];
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("addr%0d", i), addr[i], m_pc[i]);
      check_eq($sformatf("valid%0d", i), 64'(valid[i]), 64'(m_valid[i]));
      check_eq($sformatf("inst%0d", i), 64'(inst[i]), 64'(m_inst[i]));
      check_eq($sformatf("instpc%0d", i), ipc[i], m_ipc[i]);
`ifdef FETCH_STATS_EN
      check_eq($sformatf("fetchcnt%0d", i), 64'(fcnt[i]), 64'(m_fc[i]));
      check_eq($sformatf("redircnt%0d", i), 64'(rcnt[i]), 64'(m_rc[i]));
`endif
    end
  endtask

  // called just after a falling edge: drive inputs, take one rising edge, check at the next fall
  task automatic step(input logic rd, input logic [63:0] tgt, input logic rdy);
    Redirect       = rd;
    RedirectTarget = tgt;
    InstReady      = rdy;
    for (int i = 0; i < 2; i++) begin
      // memory only returns the true word on the edge the fetch should capture; garbage otherwise
      data[i] = (!m_valid[i] && m_wait[i] == 1) ? mem_word(m_pc[i]) : $urandom;
    end
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  initial begin
    logic [63:0] tgt;
    data[0] = 32'h0;
    data[1] = 32'h0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    check_eq("rst_valid0", 64'(valid[0]), 64'd0);
    check_eq("rst_addr1", addr[1], 64'hFFFF_FFFF_FFFF_FFFC);
    compare_all();

    // first word at address 0, then the next sequential PC
    step(1'b0, 64'h0, 1'b1);
    check_eq("t1_inst", 64'(inst[0]), 64'hF840_03E9);
    check_eq("t1_pc", ipc[0], 64'h0);
    step(1'b0, 64'h0, 1'b1);
    step(1'b0, 64'h0, 1'b1);
    check_eq("t1_pc_next", ipc[0], 64'h4);
    check_eq("t5_lat3", 64'(valid[1]), 64'd1);

    // decode stalls, then accepts
    repeat (5) step(1'b0, 64'h0, 1'b0);
    check_eq("t2_hold_pc", ipc[0], 64'h4);
    check_eq("t2_hold_addr", addr[0], 64'h4);
    step(1'b0, 64'h0, 1'b1);
    check_eq("t2_step", addr[0], 64'h8);
    check_eq("t5_wrap", addr[1], 64'h0);

    // redirect during fetch
    step(1'b1, 64'h1F, 1'b0);
    check_eq("t3_addr", addr[0], 64'h1C);
    step(1'b0, 64'h0, 1'b0);
    check_eq("t3_pc", ipc[0], 64'h1C);

    // redirect coinciding with a handshake
    step(1'b1, 64'h28, 1'b0);
    step(1'b0, 64'h0, 1'b0);
    check_eq("t4_pre", ipc[0], 64'h28);
    step(1'b1, 64'h1C, 1'b1);
    check_eq("t4_addr", addr[0], 64'h1C);
    step(1'b0, 64'h0, 1'b1);
    check_eq("t4_pc", ipc[0], 64'h1C);

    // randomized traffic, including redirects near the top of the address space
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      else tgt = {$urandom, $urandom};
      step(($urandom_range(7) == 0), tgt, ($urandom_range(9) < 7));
    end

    // async reset while both instances hold a valid word
    step(1'b1, 64'h100, 1'b0);
    repeat (3) step(1'b0, 64'h0, 1'b0);
    check_eq("t6_pre_valid", 64'(valid[1]), 64'd1);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_eq("t6_valid0", 64'(valid[0]), 64'd0);
    check_eq("t6_valid1", 64'(valid[1]), 64'd0);
    check_eq("t6_addr0", addr[0], 64'h0);
    check_eq("t6_addr1", addr[1], 64'hFFFF_FFFF_FFFF_FFFC);
    compare_all();
    @(negedge CLK);
    Reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step(($urandom_range(7) == 0), {$urandom, $urandom}, ($urandom_range(1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
